dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Pipeline MEM stage with a handshaked data-memory port, replacing the fixed-latency RAM access between the EX/MEM and MEM/WB registers. Takes the EX/MEM bundle, drives a req/ack memory interface with a timeout guard, stalls everything upstream while an access is outstanding, and registers the MEM/WB bundle consumed by WB_Stage. Runs entirely on the pipeline clock; no second memory clock.

## Interface
- DATA_W, 32, data/ALU width
- ADDR_W, 8, memory address width; address = EX_MEM_ALUResult[ADDR_W-1:0]
- REG_W, 5, register index width
- TIMEOUT, 15, max WAIT cycles without ack before abort (1..255)

- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- EX_MEM_Valid  in  1  EX/MEM holds a real instruction
- EX_MEM_ALUResult  in  DATA_W  ALU result / effective address
- EX_MEM_WriteData  in  DATA_W  store data
- EX_MEM_WriteReg  in  REG_W  destination register
- EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite  in  1 each  control bits
- Stall  out  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM
- mem_req  out  1  registered request, level until ack
- mem_we  out  1  registered; 1 = write
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered store data
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- mem_ack  in  1  single-cycle completion
- MEM_WB_Valid, MEM_WB_MemToReg, MEM_WB_RegWrite  out  1 each  registered
- MEM_WB_ALUResult, MEM_WB_ReadData  out  DATA_W  registered
- MEM_WB_WriteReg  out  REG_W  registered
- MemFault  out  1  registered one-cycle pulse: timeout or illegal op

## Operation
- States: IDLE, WAIT. memop = EX_MEM_Valid & (MemRead ^ MemWrite); illegal = EX_MEM_Valid & MemRead & MemWrite.
- IDLE, no memop, not illegal: at edge, MEM_WB_* <= EX_MEM_* passthrough, ReadData <= 0, Valid <= EX_MEM_Valid.
- IDLE, memop: Stall=1. At edge: mem_req<=1, mem_we<=MemWrite, mem_addr/mem_wdata latched, wait counter<=0, instruction bundle latched internally, MEM_WB_Valid<=0, MEM_WB_RegWrite<=0 (bubble), -> WAIT.
- WAIT, mem_ack=0: Stall=1, counter++, bubble into MEM_WB. If counter reaches TIMEOUT-1 at this edge: mem_req<=0, MemFault<=1, bubble, -> IDLE (Stall=0 in that final cycle).
- WAIT, mem_ack=1: Stall=0. At edge: mem_req<=0, MEM_WB loaded from latched bundle, ReadData<=mem_rdata for reads (0 for writes), Valid<=1, -> IDLE.
- Illegal (both read and write): no access, Stall=0, MemFault<=1, bubble into MEM_WB, RegWrite suppressed.
- mem_ack while IDLE (late ack after timeout) ignored.
- Latched bundle, not live EX_MEM inputs, feeds MEM_WB on completion.

## Timing
- Reset: state IDLE, counter 0, mem_req/mem_we 0, mem_addr/mem_wdata 0, all MEM_WB_* 0, MemFault 0; Stall = 0 while rst low.
- Non-memory instruction: 1-cycle latency, no stall.
- Memory op presented cycle N, ack in cycle N+k (k>=1): Stall high cycles N..N+k-1, low in N+k; MEM_WB valid after edge N+k. Minimum 1 stall cycle.
- Timeout: mem_req high exactly TIMEOUT cycles; MemFault high the cycle after.
- Back-to-back memory ops: the op following a completion enters IDLE path the next cycle; mem_req drops for at least one cycle between requests.
- Reset asserted in WAIT: mem_req drops immediately (async), no MEM_WB write, no MemFault.

## Test plan
- Reset then ALU op ALUResult=42, WriteReg=3, RegWrite=1: MEM_WB_ALUResult=42, WriteReg=3, Valid=1 one cycle later, Stall never high.
- Load addr 0x10, ack after 3 cycles with rdata=0xDEADBEEF: mem_req high 3 cycles, Stall high 3 cycles, MEM_WB_ReadData=0xDEADBEEF, MemToReg=1, Valid=1.
- Store addr 0x20, data 7, ack next cycle: mem_we=1, mem_wdata=7, one stall cycle, MEM_WB_RegWrite=0, Valid=1.
- Load, no ack: after 15 cycles mem_req=0, MemFault pulse 1 cycle, MEM_WB_Valid=0; late ack 2 cycles later ignored.
- MemRead=MemWrite=1: no mem_req, MemFault=1, no stall; next instruction flows normally.
- rst low during WAIT: mem_req=0 and MEM_WB_*=0 immediately; after release, new load completes correctly.

Source files
------------

// File: rtl/dmem_access_unit.sv
// MEM stage with a req/ack data-memory port. It stalls upstream while an access is
// outstanding, aborts on timeout, and registers the MEM/WB bundle.
module dmem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_Valid,
  input  logic [DATA_W-1:0] EX_MEM_ALUResult,
  input  logic [DATA_W-1:0] EX_MEM_WriteData,
  input  logic [REG_W-1:0]  EX_MEM_WriteReg,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_MemWrite,
  input  logic              EX_MEM_MemToReg,
  input  logic              EX_MEM_RegWrite,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              MEM_WB_Valid,
  output logic              MEM_WB_MemToReg,
  output logic              MEM_WB_RegWrite,
  output logic [DATA_W-1:0] MEM_WB_ALUResult,
  output logic [DATA_W-1:0] MEM_WB_ReadData,
  output logic [REG_W-1:0]  MEM_WB_WriteReg,
  output logic              MemFault
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t state, state_next;
  logic [7:0] wait_cnt;
  logic memop, illegal;
  logic start, complete, abort;

  logic [DATA_W-1:0] lat_alu;
  logic [REG_W-1:0]  lat_wreg;
  logic lat_m2r, lat_rw, lat_read;

  assign memop   = EX_MEM_Valid & (EX_MEM_MemRead ^ EX_MEM_MemWrite);
  assign illegal = EX_MEM_Valid & EX_MEM_MemRead & EX_MEM_MemWrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Ack wins over timeout when both land in the last wait cycle.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    Stall      = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          start      = 1'b1;
          Stall      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          Stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rst) Stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt         <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      lat_alu          <= '0;
      lat_wreg         <= '0;
      lat_m2r          <= 1'b0;
      lat_rw           <= 1'b0;
      lat_read         <= 1'b0;
      MEM_WB_Valid     <= 1'b0;
      MEM_WB_MemToReg  <= 1'b0;
      MEM_WB_RegWrite  <= 1'b0;
      MEM_WB_ALUResult <= '0;
      MEM_WB_ReadData  <= '0;
      MEM_WB_WriteReg  <= '0;
      MemFault         <= 1'b0;
    end else begin
      MemFault <= 1'b0;
      if (start) begin
        mem_req         <= 1'b1;
        mem_we          <= EX_MEM_MemWrite;
        mem_addr        <= EX_MEM_ALUResult[ADDR_W-1:0];
        mem_wdata       <= EX_MEM_WriteData;
        wait_cnt        <= '0;
        lat_alu         <= EX_MEM_ALUResult;
        lat_wreg        <= EX_MEM_WriteReg;
        lat_m2r         <= EX_MEM_MemToReg;
        lat_rw          <= EX_MEM_RegWrite;
        lat_read        <= EX_MEM_MemRead;
        MEM_WB_Valid    <= 1'b0;
        MEM_WB_RegWrite <= 1'b0;
      end else if (complete) begin
        mem_req          <= 1'b0;
        MEM_WB_Valid     <= 1'b1;
        MEM_WB_ALUResult <= lat_alu;
        MEM_WB_WriteReg  <= lat_wreg;
        MEM_WB_MemToReg  <= lat_m2r;
        MEM_WB_RegWrite  <= lat_rw;
        MEM_WB_ReadData  <= lat_read ? mem_rdata : '0;
      end else if (abort) begin
        mem_req         <= 1'b0;
        MemFault        <= 1'b1;
        MEM_WB_Valid    <= 1'b0;
        MEM_WB_RegWrite <= 1'b0;
      end else if (state == WAIT) begin
        wait_cnt        <= wait_cnt + 8'd1;
        MEM_WB_Valid    <= 1'b0;
        MEM_WB_RegWrite <= 1'b0;
      end else if (illegal) begin
        MemFault        <= 1'b1;
        MEM_WB_Valid    <= 1'b0;
        MEM_WB_RegWrite <= 1'b0;
      end else begin
        MEM_WB_Valid     <= EX_MEM_Valid;
        MEM_WB_ALUResult <= EX_MEM_ALUResult;
        MEM_WB_WriteReg  <= EX_MEM_WriteReg;
        MEM_WB_MemToReg  <= EX_MEM_MemToReg;
        MEM_WB_RegWrite  <= EX_MEM_RegWrite;
        MEM_WB_ReadData  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: table of single-cycle instructions plus hand-written
// load/store/timeout/reset sequences, with a MEM/WB scoreboard queue.
module tb_dmem_access_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic EX_MEM_Valid = 1'b0;
  logic [DATA_W-1:0] EX_MEM_ALUResult = '0;
  logic [DATA_W-1:0] EX_MEM_WriteData = '0;
  logic [REG_W-1:0]  EX_MEM_WriteReg = '0;
  logic EX_MEM_MemRead = 1'b0, EX_MEM_MemWrite = 1'b0;
  logic EX_MEM_MemToReg = 1'b0, EX_MEM_RegWrite = 1'b0;
  logic Stall, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic MEM_WB_Valid, MEM_WB_MemToReg, MEM_WB_RegWrite;
  logic [DATA_W-1:0] MEM_WB_ALUResult, MEM_WB_ReadData;
  logic [REG_W-1:0]  MEM_WB_WriteReg;
  logic MemFault;

  int total = 0;
  int bad   = 0;

  dmem_access_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_Valid(EX_MEM_Valid), .EX_MEM_ALUResult(EX_MEM_ALUResult),
    .EX_MEM_WriteData(EX_MEM_WriteData), .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_MemToReg(EX_MEM_MemToReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .Stall(Stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .MEM_WB_Valid(MEM_WB_Valid), .MEM_WB_MemToReg(MEM_WB_MemToReg),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_ALUResult(MEM_WB_ALUResult),
    .MEM_WB_ReadData(MEM_WB_ReadData), .MEM_WB_WriteReg(MEM_WB_WriteReg),
    .MemFault(MemFault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid, regwrite, memtoreg, fault, chk_data;
    logic [31:0] alu, rdata;
    logic [4:0]  wreg;
  } wb_t;

  typedef struct {
    string name;
    logic v;
    logic [31:0] alu, wd;
    logic [4:0] wr;
    logic rd, we, m2r, rw;
    logic e_stall;
    wb_t e;
  } vec_t;

  wb_t  sb[$];
  vec_t vecs[$];

  function automatic wb_t mkWb(input logic valid, rw, m2r, fault, chk,
                               input logic [31:0] alu, rdata, input logic [4:0] wreg);
    wb_t w;
    w.valid = valid; w.regwrite = rw; w.memtoreg = m2r; w.fault = fault;
    w.chk_data = chk; w.alu = alu; w.rdata = rdata; w.wreg = wreg;
    return w;
  endfunction

  function automatic vec_t mkVec(input string n, input logic v, input logic [31:0] alu, wd,
                                 input logic [4:0] wr, input logic rd, we, m2r, rw,
                                 input logic e_stall, input wb_t e);
    vec_t t;
    t.name = n; t.v = v; t.alu = alu; t.wd = wd; t.wr = wr;
    t.rd = rd; t.we = we; t.m2r = m2r; t.rw = rw; t.e_stall = e_stall; t.e = e;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkWb(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_sb_empty: got 0 entries expected 1", tag);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_valid"}, 32'(MEM_WB_Valid), 32'(e.valid));
    checkOutput({tag, "_regwrite"}, 32'(MEM_WB_RegWrite), 32'(e.regwrite));
    checkOutput({tag, "_fault"}, 32'(MemFault), 32'(e.fault));
    if (e.chk_data) begin
      checkOutput({tag, "_alu"}, MEM_WB_ALUResult, e.alu);
      checkOutput({tag, "_rdata"}, MEM_WB_ReadData, e.rdata);
      checkOutput({tag, "_wreg"}, 32'(MEM_WB_WriteReg), 32'(e.wreg));
      checkOutput({tag, "_memtoreg"}, 32'(MEM_WB_MemToReg), 32'(e.memtoreg));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] alu, wd, input logic [4:0] wr,
                               input logic rd, we, m2r, rw);
    EX_MEM_Valid     = v;
    EX_MEM_ALUResult = alu;
    EX_MEM_WriteData = wd;
    EX_MEM_WriteReg  = wr;
    EX_MEM_MemRead   = rd;
    EX_MEM_MemWrite  = we;
    EX_MEM_MemToReg  = m2r;
    EX_MEM_RegWrite  = rw;
  endtask

  // Memory op with the ack arriving k cycles after the op is presented; called at a negedge.
  task automatic memOp(input string tag, input logic we, input logic [31:0] addr, wd,
                       input logic [4:0] wr, input logic m2r, rw, input int k,
                       input logic [31:0] rdata);
    int stall_cnt = 0;
    int req_cnt   = 0;
    applyStimulus(1'b1, addr, wd, wr, ~we, we, m2r, rw);
    for (int c = 0; c < k; c++) begin
      #1;
      if (Stall) stall_cnt++;
      if (mem_req) req_cnt++;
      @(posedge clk); #1;
      if (c == 0) begin
        checkOutput({tag, "_req"}, 32'(mem_req), 32'd1);
        checkOutput({tag, "_we"}, 32'(mem_we), 32'(we));
        checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(addr[ADDR_W-1:0]));
        if (we) checkOutput({tag, "_wdata"}, mem_wdata, wd);
        checkOutput({tag, "_bubble"}, 32'(MEM_WB_Valid), 32'd0);
        EX_MEM_ALUResult = 32'h99;
        EX_MEM_WriteReg  = 5'd9;
      end
      @(negedge clk);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1;
    checkOutput({tag, "_stall_on_ack"}, 32'(Stall), 32'd0);
    if (mem_req) req_cnt++;
    sb.push_back(mkWb(1'b1, rw, m2r, 1'b0, 1'b1, addr, we ? 32'd0 : rdata, wr));
    @(posedge clk); #1;
    checkWb(tag);
    checkOutput({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(k));
    checkOutput({tag, "_req_cycles"}, 32'(req_cnt), 32'(k));
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int req_cnt, fault_cnt, fault_idx, valid_cnt, stall_cnt;

    // Reset state, with a load presented to confirm Stall stays low in reset.
    applyStimulus(1'b1, 32'h10, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    #12;
    checkOutput("rst_stall", 32'(Stall), 32'd0);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_valid", 32'(MEM_WB_Valid), 32'd0);
    checkOutput("rst_alu", MEM_WB_ALUResult, 32'd0);
    checkOutput("rst_fault", 32'(MemFault), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    vecs.push_back(mkVec("alu42", 1, 32'd42, 0, 5'd3, 0, 0, 0, 1, 0,
                         mkWb(1, 1, 0, 0, 1, 32'd42, 0, 5'd3)));
    vecs.push_back(mkVec("nop", 0, 32'd5, 0, 5'd1, 0, 0, 0, 0, 0,
                         mkWb(0, 0, 0, 0, 1, 32'd5, 0, 5'd1)));
    vecs.push_back(mkVec("illegal", 1, 32'h30, 32'd9, 5'd2, 1, 1, 0, 1, 0,
                         mkWb(0, 0, 0, 1, 0, 0, 0, 5'd0)));
    vecs.push_back(mkVec("after_illegal", 1, 32'h1234, 0, 5'd7, 0, 0, 0, 1, 0,
                         mkWb(1, 1, 0, 0, 1, 32'h1234, 0, 5'd7)));
    vecs.push_back(mkVec("all_ones", 1, 32'hFFFF_FFFF, 0, 5'd31, 0, 0, 1, 1, 0,
                         mkWb(1, 1, 1, 0, 1, 32'hFFFF_FFFF, 0, 5'd31)));
    vecs.push_back(mkVec("invalid_read", 0, 32'h77, 0, 5'd4, 1, 0, 1, 0, 0,
                         mkWb(0, 0, 1, 0, 1, 32'h77, 0, 5'd4)));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].alu, vecs[i].wd, vecs[i].wr,
                    vecs[i].rd, vecs[i].we, vecs[i].m2r, vecs[i].rw);
      #1;
      checkOutput({vecs[i].name, "_stall"}, 32'(Stall), 32'(vecs[i].e_stall));
      sb.push_back(vecs[i].e);
      @(posedge clk); #1;
      checkWb(vecs[i].name);
      checkOutput({vecs[i].name, "_noreq"}, 32'(mem_req), 32'd0);
      @(negedge clk);
    end

    memOp("load3", 1'b0, 32'h10, 32'd0, 5'd4, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
    memOp("store1", 1'b1, 32'h20, 32'd7, 5'd0, 1'b0, 1'b0, 1, 32'h5555_5555);
    memOp("b2b_load", 1'b0, 32'h1A4, 32'd0, 5'd11, 1'b1, 1'b1, 2, 32'h0BAD_F00D);

    // Timeout: no ack, then a stray ack two cycles after the fault pulse.
    applyStimulus(1'b1, 32'h40, 32'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("to_stall_idle", 32'(Stall), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    req_cnt = 0; fault_cnt = 0; fault_idx = -1; valid_cnt = 0; stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) req_cnt++;
      if (Stall) stall_cnt++;
      if (MEM_WB_Valid) valid_cnt++;
      if (MemFault) begin
        fault_cnt++;
        if (fault_idx < 0) fault_idx = i;
      end
      mem_ack = (fault_idx >= 0 && i == fault_idx + 2);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    checkOutput("to_req_cycles", 32'(req_cnt), 32'(TIMEOUT));
    checkOutput("to_wait_stalls", 32'(stall_cnt), 32'(TIMEOUT - 1));
    checkOutput("to_fault_idx", 32'(fault_idx), 32'(TIMEOUT));
    checkOutput("to_fault_pulses", 32'(fault_cnt), 32'd1);
    checkOutput("to_valid_cycles", 32'(valid_cnt), 32'd0);
    checkOutput("to_req_end", 32'(mem_req), 32'd0);
    @(negedge clk);

    // Reset asserted mid-access.
    applyStimulus(1'b1, 32'hABCD, 32'd0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("pre_rst_alu", MEM_WB_ALUResult, 32'hABCD);
    @(negedge clk);
    applyStimulus(1'b1, 32'h50, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput("wait_rst_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("wait_rst_req", 32'(mem_req), 32'd0);
    checkOutput("wait_rst_valid", 32'(MEM_WB_Valid), 32'd0);
    checkOutput("wait_rst_alu", MEM_WB_ALUResult, 32'd0);
    checkOutput("wait_rst_wreg", 32'(MEM_WB_WriteReg), 32'd0);
    checkOutput("wait_rst_fault", 32'(MemFault), 32'd0);
    checkOutput("wait_rst_stall", 32'(Stall), 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    memOp("post_rst_load", 1'b0, 32'h60, 32'd0, 5'd8, 1'b1, 1'b1, 2, 32'hCAFE_F00D);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
